chase_tracker: RTL and testbench
================================

# chase_tracker

Parametrised turn-and-position tracker for the chicken-chase board game. Holds one position register per player on a circular board and accepts one move per handshake from the tile-match logic. On a hit it advances the current player; on a miss it passes the turn. After each advance it declares a win when the mover lands on any other player's square. Sits between the card/tile-match front end and the display/score logic.

## Interface
- NUM_PLAYERS, 4, player count, 2..8
- BOARD_LEN, 24, squares on the circular board; NUM_PLAYERS <= BOARD_LEN <= 2**POS_W
- POS_W, 5, position width
- STEP_W, 5, move step width
- Derived: TURN_W = max(1, $clog2(NUM_PLAYERS))
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse; (re)initialises the game from any state
- move_vld  in  1  move offered
- move_hit  in  1  1 = tile matched (advance), 0 = miss (pass turn)
- move_step  in  STEP_W  squares to advance on a hit
- move_rdy  out  1  move can be accepted this cycle
- turn  out  TURN_W  index of the player to move
- pos_out  out  POS_W  mover's position after the latest advance
- pos_vld  out  1  one-cycle pulse: advance completed, no win
- win  out  1  level; game won, held until start
- winner  out  TURN_W  winning player, valid while win = 1
- busy  out  1  high in UPDATE and CHECK

## Operation
- States: IDLE, READY, UPDATE, CHECK, WON.
- IDLE: entered on reset; move_rdy = 0; waits for start.
- start, sampled in any state (priority over everything, including a move in flight):
  - pos[i] = i * (BOARD_LEN / NUM_PLAYERS) (integer division)
  - turn = 0; win = 0; winner = 0; pos_out = 0
  - go to READY
- READY: move_rdy = 1. A move is accepted on the edge where move_vld & move_rdy.
  - Miss: turn = (turn + 1) wrapped at NUM_PLAYERS; stay in READY.
  - Hit: register step_eff, then go to UPDATE.
  - step_eff = min(move_step, BOARD_LEN - 1).
  - Hit with step_eff = 0: treated as a miss.
- UPDATE:
  - sum = pos[turn] + step_eff, computed at POS_W+1 bits.
  - New position = sum - BOARD_LEN if sum >= BOARD_LEN, else sum. One conditional subtract; wrap-around only.
  - The new position is written to pos[turn] and pos_out. Go to CHECK.
- CHECK: compare pos[turn] against pos[j] for every j != turn.
  - Any equal: win = 1, winner = turn; go to WON.
  - Otherwise: pos_vld = 1 for this cycle; go to READY. turn is unchanged, so the player keeps moving after a hit.
- Only the landing square counts. Passing over another player is not a capture.
- WON: move_rdy = 0; positions frozen; move_vld is ignored. Only start or rst leaves WON.
- Reset values: move_rdy = 0, turn = 0, pos_out = 0, pos_vld = 0, win = 0, winner = 0, busy = 0; all pos[i] = 0; state = IDLE.

## Timing
- Miss accepted at edge k: turn updates at k; move_rdy stays high.
- Hit accepted at edge k:
  - UPDATE during cycle k..k+1; pos_out valid after edge k+1.
  - CHECK during cycle k+1..k+2; pos_vld or win asserts during that cycle (combinational from CHECK state and compare), with win registered at edge k+2.
  - move_rdy returns high in the cycle after edge k+2.
- Throughput: one hit per 3 cycles; one miss per cycle.
- start during UPDATE or CHECK aborts the move. No pos_vld and no win result from the aborted move; state is READY after the edge.
- start and move_vld in the same cycle: start wins and the move is dropped.
- rst deassertion is synchronised externally; the block is asynchronous on assertion only.

## Structure
- Shared package chase_pkg holds:
  - state enum (IDLE, READY, UPDATE, CHECK, WON)
  - TURN_W helper
  - init_pos(i, players, len) function
  - wrap_add(pos, step, len) function
- Sub-module pos_match:
  - inputs: packed pos array, mover index
  - output: hit flag
  - combinational comparison of the mover's position against every other player's position
- Top level holds the FSM, the position register file, and the turn counter.

## Test plan
- Reset, then start with NUM_PLAYERS=4, BOARD_LEN=24 -> pos = {0,6,12,18}; turn = 0; move_rdy = 1; win = 0.
- Three misses, then a hit with step 3 -> turn = 3; pos[3] = 21; pos_vld pulses two cycles after acceptance; turn stays 3.
- From the initial layout, player 3 hits with step 6 -> sum 24 wraps to 0 (equals pos[0]); win = 1, winner = 3; move_rdy = 0; further moves are ignored.
- Player 0 hits with step 30 -> clamped to 23; pos[0] = 23; no win.
- Hit with step 0 -> behaves as a miss; turn advances to 1; no pos_vld.
- start asserted during UPDATE -> positions reinitialised; no pos_vld or win; READY next cycle. rst low mid-CHECK -> all outputs at reset values immediately.

Source files
------------

// File: rtl/chase_pkg.sv
// Shared types and helpers for the chicken-chase turn/position tracker.
package chase_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        UPDATE,
        CHECK,
        WON
    } state_t;

    function automatic int turn_w(input int players);
        return (players <= 2) ? 1 : $clog2(players);
    endfunction

    function automatic int init_pos(input int i, input int players, input int len);
        return i * (len / players);
    endfunction

    // A single conditional subtract is enough because step is clamped below len.
    function automatic int wrap_add(input int pos, input int step, input int len);
        int sum;
        sum = pos + step;
        return (sum >= len) ? sum - len : sum;
    endfunction

endpackage

// File: rtl/chase_tracker_if.sv
// Move handshake between the tile-match front end and the tracker.
interface chase_tracker_if #(
    parameter int STEP_W = 5
);
    logic              move_vld;
    logic              move_hit;
    logic [STEP_W-1:0] move_step;
    logic              move_rdy;

    modport master (output move_vld, output move_hit, output move_step, input move_rdy);
    modport slave  (input move_vld, input move_hit, input move_step, output move_rdy);
endinterface

// File: rtl/chase_tracker_pos_match.sv
// Flags when the mover shares a square with any other player.
module pos_match #(
    parameter int NUM_PLAYERS = 4,
    parameter int POS_W       = 5,
    parameter int TURN_W      = 2
) (
    input  logic [NUM_PLAYERS-1:0][POS_W-1:0] pos,
    input  logic [TURN_W-1:0]                 mover,
    output logic                              hit
);
    logic [POS_W-1:0] mover_pos;

    always_comb begin
        hit       = 1'b0;
        mover_pos = pos[mover];
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            if ((TURN_W'(j) != mover) && (pos[j] == mover_pos)) begin
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/chase_tracker.sv
// Turn and position tracker: FSM, per-player position registers and turn counter.
module chase_tracker
    import chase_pkg::*;
#(
    parameter int  NUM_PLAYERS = 4,
    parameter int  BOARD_LEN   = 24,
    parameter int  POS_W       = 5,
    parameter int  STEP_W      = 5,
    localparam int TURN_W      = turn_w(NUM_PLAYERS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    chase_tracker_if.slave    mv,
    output logic [TURN_W-1:0] turn,
    output logic [POS_W-1:0]  pos_out,
    output logic              pos_vld,
    output logic              win,
    output logic [TURN_W-1:0] winner,
    output logic              busy
);
    localparam int MAX_STEP = BOARD_LEN - 1;

    state_t                           state, state_nxt;
    logic [NUM_PLAYERS-1:0][POS_W-1:0] pos;
    logic [POS_W-1:0]                 step_eff;
    logic [POS_W-1:0]                 step_clamp;
    logic [POS_W-1:0]                 new_pos;
    logic                             win_r;
    logic [TURN_W-1:0]                winner_r;
    logic                             accept;
    logic                             is_hit;
    logic                             match;
    logic                             win_now;

    assign step_clamp = (int'(mv.move_step) > MAX_STEP) ? POS_W'(MAX_STEP) : POS_W'(mv.move_step);
    assign accept     = (state == READY) && mv.move_vld && !start;
    assign is_hit     = mv.move_hit && (step_clamp != '0);
    assign new_pos    = POS_W'(wrap_add(int'(pos[turn]), int'(step_eff), BOARD_LEN));

    pos_match #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .POS_W       (POS_W),
        .TURN_W      (TURN_W)
    ) u_match (
        .pos   (pos),
        .mover (turn),
        .hit   (match)
    );

    // A start in CHECK aborts the move, so it also masks the result pulses.
    assign win_now     = (state == CHECK) && match && !start;
    assign pos_vld     = (state == CHECK) && !match && !start;
    assign win         = win_r | win_now;
    assign winner      = win_now ? turn : winner_r;
    assign busy        = (state == UPDATE) || (state == CHECK);
    assign mv.move_rdy = (state == READY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = READY;
        end else begin
            case (state)
                READY:   if (accept && is_hit) state_nxt = UPDATE;
                UPDATE:  state_nxt = CHECK;
                CHECK:   state_nxt = match ? WON : READY;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos      <= '0;
            turn     <= '0;
            pos_out  <= '0;
            step_eff <= '0;
            win_r    <= 1'b0;
            winner_r <= '0;
        end else if (start) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos[i] <= POS_W'(init_pos(i, NUM_PLAYERS, BOARD_LEN));
            end
            turn     <= '0;
            pos_out  <= '0;
            win_r    <= 1'b0;
            winner_r <= '0;
        end else begin
            case (state)
                READY: begin
                    if (accept) begin
                        if (is_hit) begin
                            step_eff <= step_clamp;
                        end else begin
                            turn <= (int'(turn) == NUM_PLAYERS - 1) ? '0 : turn + TURN_W'(1);
                        end
                    end
                end
                UPDATE: begin
                    pos[turn] <= new_pos;
                    pos_out   <= new_pos;
                end
                CHECK: begin
                    if (match) begin
                        win_r    <= 1'b1;
                        winner_r <= turn;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chase_tracker.sv
// Self-checking bench for chase_tracker: directed table, corner sequences, random vs. model.
module tb_chase_tracker;
    localparam int NP = 4;
    localparam int BL = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] turn;
    logic [4:0] pos_out;
    logic       pos_vld;
    logic       win;
    logic [1:0] winner;
    logic       busy;

    int checks = 0;
    int errors = 0;

    chase_tracker_if #(.STEP_W(5)) mif ();

    chase_tracker #(
        .NUM_PLAYERS (NP),
        .BOARD_LEN   (BL),
        .POS_W       (5),
        .STEP_W      (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mv      (mif),
        .turn    (turn),
        .pos_out (pos_out),
        .pos_vld (pos_vld),
        .win     (win),
        .winner  (winner),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit hit;
        int step;
        int exp_turn;
        int exp_pos;
        bit exp_vld;
        bit exp_win;
        int exp_winner;
    } vec_t;

    vec_t tbl[8];

    int mpos[NP];
    int mturn;
    bit mwon;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_start();
        for (int i = 0; i < NP; i++) mpos[i] = i * (BL / NP);
        mturn = 0;
        mwon  = 1'b0;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic apply(input bit hit, input int step,
                         output int o_turn, output int o_pos, output int o_vld0,
                         output int o_vld1, output int o_win, output int o_winner,
                         output int o_rdy);
        int n;
        n = 0;
        while (!mif.move_rdy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!mif.move_rdy) chk("rdy_timeout", 0, 1);
        mif.move_vld  = 1'b1;
        mif.move_hit  = hit;
        mif.move_step = 5'(step);
        @(posedge clk);
        #1;
        mif.move_vld = 1'b0;
        o_vld0 = int'(pos_vld);
        @(posedge clk);
        #1;
        o_vld1 = int'(pos_vld);
        o_pos  = int'(pos_out);
        @(posedge clk);
        #1;
        o_turn   = int'(turn);
        o_win    = int'(win);
        o_winner = int'(winner);
        o_rdy    = int'(mif.move_rdy);
    endtask

    initial begin
        int t, p, v0, v1, w, wn, r;
        mif.move_vld  = 1'b0;
        mif.move_hit  = 1'b0;
        mif.move_step = '0;

        tbl[0] = '{0, 0,  1, 0,  0, 0, 0};
        tbl[1] = '{0, 7,  2, 0,  0, 0, 0};
        tbl[2] = '{0, 3,  3, 0,  0, 0, 0};
        tbl[3] = '{1, 3,  3, 21, 1, 0, 0};
        tbl[4] = '{1, 0,  0, 0,  0, 0, 0};
        tbl[5] = '{1, 30, 0, 23, 1, 0, 0};
        tbl[6] = '{1, 1,  0, 0,  1, 0, 0};
        tbl[7] = '{1, 6,  0, 6,  0, 1, 0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", int'(mif.move_rdy), 0);
        chk("rst_turn", int'(turn), 0);
        chk("rst_pos_out", int'(pos_out), 0);
        chk("rst_pos_vld", int'(pos_vld), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pos3", int'(dut.pos[3]), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_rdy", int'(mif.move_rdy), 0);

        do_start();
        chk("start_rdy", int'(mif.move_rdy), 1);
        chk("start_turn", int'(turn), 0);
        chk("start_win", int'(win), 0);
        for (int i = 0; i < NP; i++) chk($sformatf("start_pos%0d", i), int'(dut.pos[i]), i * 6);

        // directed table
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].hit, tbl[i].step, t, p, v0, v1, w, wn, r);
            chk($sformatf("tbl%0d_turn", i), t, tbl[i].exp_turn);
            chk($sformatf("tbl%0d_vld_early", i), v0, 0);
            chk($sformatf("tbl%0d_vld", i), v1, int'(tbl[i].exp_vld));
            chk($sformatf("tbl%0d_win", i), w, int'(tbl[i].exp_win));
            chk($sformatf("tbl%0d_rdy", i), r, tbl[i].exp_win ? 0 : 1);
            if (tbl[i].hit && tbl[i].step != 0) chk($sformatf("tbl%0d_pos", i), p, tbl[i].exp_pos);
            if (tbl[i].exp_win) chk($sformatf("tbl%0d_winner", i), wn, tbl[i].exp_winner);
        end

        // moves in WON are ignored
        @(negedge clk);
        mif.move_vld  = 1'b1;
        mif.move_hit  = 1'b1;
        mif.move_step = 5'd3;
        repeat (3) @(negedge clk);
        mif.move_vld = 1'b0;
        chk("won_rdy", int'(mif.move_rdy), 0);
        chk("won_win", int'(win), 1);
        chk("won_winner", int'(winner), 0);
        chk("won_busy", int'(busy), 0);
        chk("won_pos0", int'(dut.pos[0]), 6);
        chk("won_pos3", int'(dut.pos[3]), 21);

        // start during UPDATE aborts the move
        do_start();
        chk("restart_win", int'(win), 0);
        @(negedge clk);
        mif.move_vld  = 1'b1;
        mif.move_hit  = 1'b1;
        mif.move_step = 5'd6;
        @(posedge clk);
        #1;
        mif.move_vld = 1'b0;
        chk("upd_busy", int'(busy), 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("abort_upd_rdy", int'(mif.move_rdy), 1);
        chk("abort_upd_busy", int'(busy), 0);
        chk("abort_upd_vld", int'(pos_vld), 0);
        chk("abort_upd_pos0", int'(dut.pos[0]), 0);
        @(posedge clk);
        #1;
        chk("abort_upd_vld2", int'(pos_vld), 0);
        chk("abort_upd_win2", int'(win), 0);

        // start during CHECK masks a would-be win
        @(negedge clk);
        mif.move_vld  = 1'b1;
        mif.move_hit  = 1'b1;
        mif.move_step = 5'd6;
        @(posedge clk);
        #1;
        mif.move_vld = 1'b0;
        @(posedge clk);
        #1;
        chk("chk_pos_out", int'(pos_out), 6);
        start = 1'b1;
        #1;
        chk("abort_chk_win", int'(win), 0);
        chk("abort_chk_vld", int'(pos_vld), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("abort_chk_rdy", int'(mif.move_rdy), 1);
        chk("abort_chk_win2", int'(win), 0);
        chk("abort_chk_pos0", int'(dut.pos[0]), 0);

        // start and move in the same cycle: move dropped
        @(negedge clk);
        start         = 1'b1;
        mif.move_vld  = 1'b1;
        mif.move_hit  = 1'b1;
        mif.move_step = 5'd5;
        @(posedge clk);
        #1;
        start        = 1'b0;
        mif.move_vld = 1'b0;
        chk("same_busy", int'(busy), 0);
        chk("same_turn", int'(turn), 0);
        @(posedge clk);
        #1;
        chk("same_pos0", int'(dut.pos[0]), 0);

        // rst asserted mid-CHECK
        @(negedge clk);
        mif.move_vld  = 1'b1;
        mif.move_hit  = 1'b1;
        mif.move_step = 5'd2;
        @(posedge clk);
        #1;
        mif.move_vld = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("arst_rdy", int'(mif.move_rdy), 0);
        chk("arst_pos_out", int'(pos_out), 0);
        chk("arst_pos_vld", int'(pos_vld), 0);
        chk("arst_win", int'(win), 0);
        chk("arst_winner", int'(winner), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_turn", int'(turn), 0);
        @(negedge clk);
        rst = 1'b1;

        // randomized against the behavioural model
        do_start();
        model_start();
        for (int k = 0; k < 200; k++) begin
            bit h;
            int s, eff, np;
            bit cap;
            h   = 1'($urandom_range(0, 1));
            s   = int'($urandom_range(0, 31));
            eff = (s > BL - 1) ? BL - 1 : s;
            apply(h, s, t, p, v0, v1, w, wn, r);
            chk("rnd_vld_early", v0, 0);
            if (!h || eff == 0) begin
                mturn = (mturn + 1) % NP;
                chk("rnd_miss_vld", v1, 0);
            end else begin
                np = (mpos[mturn] + eff) % BL;
                mpos[mturn] = np;
                cap = 1'b0;
                for (int j = 0; j < NP; j++) if (j != mturn && mpos[j] == np) cap = 1'b1;
                chk("rnd_pos_out", p, np);
                chk("rnd_vld", v1, cap ? 0 : 1);
                if (cap) begin
                    chk("rnd_winner", wn, mturn);
                    mwon = 1'b1;
                end
            end
            chk("rnd_turn", t, mturn);
            chk("rnd_win", w, int'(mwon));
            chk("rnd_rdy", r, mwon ? 0 : 1);
            for (int j = 0; j < NP; j++) chk("rnd_pos", int'(dut.pos[j]), mpos[j]);
            if (mwon) begin
                do_start();
                model_start();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
